// File: rtl/bus_cpu_pkg.sv
// Shared types for the bus CPU core: opcodes, FSM states, one-hot bus-source selects.
package bus_cpu_pkg;

   typedef enum logic [2:0] {
      OP_MV  = 3'b000,
      OP_MVI = 3'b001,
      OP_ADD = 3'b010,
      OP_SUB = 3'b011,
      OP_AND = 3'b100,
      OP_OR  = 3'b101,
      OP_XOR = 3'b110,
      OP_ST  = 3'b111
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_T1,
      S_T2,
      S_T3
   } state_e;

   // One bit per bus driver so the bus is an AND-OR mux with at most one source active.
   typedef enum logic [3:0] {
      BUS_NONE = 4'b0000,
      BUS_RX   = 4'b0001,
      BUS_RY   = 4'b0010,
      BUS_DIN  = 4'b0100,
      BUS_G    = 4'b1000
   } bus_sel_e;

   function automatic logic is_alu_op(input op_e op);
      return (op != OP_MV) && (op != OP_MVI) && (op != OP_ST);
   endfunction

endpackage

// File: rtl/bus_cpu_alu.sv
// Combinational ALU for the bus CPU: ADD/SUB with carry-out, bitwise AND/OR/XOR.
module bus_cpu_alu
   import bus_cpu_pkg::*;
#(
   parameter int unsigned DATA_W = 8
) (
   input  op_e               op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] y,
   output logic              cout
);

   logic [DATA_W:0] sum;

   always_comb begin
      sum  = '0;
      y    = b;
      cout = 1'b0;
      unique case (op)
         OP_ADD: begin
            sum  = {1'b0, a} + {1'b0, b};
            y    = sum[DATA_W-1:0];
            cout = sum[DATA_W];
         end
         // Subtract as A + ~B + 1 so cout is the no-borrow indication.
         OP_SUB: begin
            sum  = {1'b0, a} + {1'b0, ~b} + (DATA_W+1)'(1);
            y    = sum[DATA_W-1:0];
            cout = sum[DATA_W];
         end
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
         OP_XOR:  y = a ^ b;
         default: y = b;
      endcase
   end

endmodule

// File: rtl/bus_cpu_core.sv
// Parametrised single-bus CPU core: register file, A/G accumulators, IDLE/T1/T2/T3 control.
// Optional Z/C flag outputs when CPU_FLAGS_EN is defined.
module bus_cpu_core
   import bus_cpu_pkg::*;
#(
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned NUM_REGS = 4
) (
   input  logic                                clk,
   input  logic                                clr_n,
   input  logic                                w,
   input  logic [3+2*$clog2(NUM_REGS)-1:0]     func,
   input  logic [DATA_W-1:0]                   data_in,
   output logic [DATA_W-1:0]                   data_out,
   output logic                                data_out_valid,
   output logic                                busy,
   output logic                                done
`ifdef CPU_FLAGS_EN
   ,
   output logic                                flag_z,
   output logic                                flag_c
`endif
);

   localparam int unsigned REG_IDX_W = $clog2(NUM_REGS);
   localparam int unsigned FUNC_W    = 3 + 2*REG_IDX_W;

   state_e                state_q, state_d;
   logic [FUNC_W-1:0]     ir_q;
   logic [DATA_W-1:0]     regs_q [NUM_REGS];
   logic [DATA_W-1:0]     a_q, g_q, dout_q;
   logic                  dvalid_q;

   op_e                   op;
   logic [REG_IDX_W-1:0]  rx, ry;
   bus_sel_e              bus_sel;
   logic [DATA_W-1:0]     bus, alu_y;
   logic                  alu_cout;
   logic                  reg_we, a_we, g_we, st_we;

   assign op = op_e'(ir_q[FUNC_W-1 -: 3]);
   assign rx = ir_q[2*REG_IDX_W-1 -: REG_IDX_W];
   assign ry = ir_q[REG_IDX_W-1:0];

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (w) state_d = S_T1;
         S_T1:    state_d = is_alu_op(op) ? S_T2 : S_IDLE;
         S_T2:    state_d = S_T3;
         S_T3:    state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      bus_sel = BUS_NONE;
      reg_we  = 1'b0;
      a_we    = 1'b0;
      g_we    = 1'b0;
      st_we   = 1'b0;
      done    = 1'b0;
      busy    = (state_q != S_IDLE);
      unique case (state_q)
         S_T1: begin
            unique case (op)
               OP_MV:   begin bus_sel = BUS_RY;  reg_we = 1'b1; done = 1'b1; end
               OP_MVI:  begin bus_sel = BUS_DIN; reg_we = 1'b1; done = 1'b1; end
               OP_ST:   begin bus_sel = BUS_RX;  st_we  = 1'b1; done = 1'b1; end
               default: begin bus_sel = BUS_RX;  a_we   = 1'b1; end
            endcase
         end
         S_T2: begin bus_sel = BUS_RY; g_we = 1'b1; end
         S_T3: begin bus_sel = BUS_G;  reg_we = 1'b1; done = 1'b1; end
         default: ;
      endcase
   end

   assign bus = ({DATA_W{bus_sel[0]}} & regs_q[rx])
              | ({DATA_W{bus_sel[1]}} & regs_q[ry])
              | ({DATA_W{bus_sel[2]}} & data_in)
              | ({DATA_W{bus_sel[3]}} & g_q);

   bus_cpu_alu #(.DATA_W(DATA_W)) u_alu (
      .op   (op),
      .a    (a_q),
      .b    (bus),
      .y    (alu_y),
      .cout (alu_cout)
   );

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         ir_q     <= '0;
         regs_q   <= '{default: '0};
         a_q      <= '0;
         g_q      <= '0;
         dout_q   <= '0;
         dvalid_q <= 1'b0;
      end else begin
         if (state_q == S_IDLE && w) ir_q <= func;
         if (reg_we) regs_q[rx] <= bus;
         if (a_we)   a_q        <= bus;
         if (g_we)   g_q        <= alu_y;
         if (st_we)  dout_q     <= bus;
         dvalid_q <= st_we;
      end
   end

   assign data_out       = dout_q;
   assign data_out_valid = dvalid_q;

`ifdef CPU_FLAGS_EN
   logic flag_z_q, flag_c_q;

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         flag_z_q <= 1'b0;
         flag_c_q <= 1'b0;
      end else if (g_we) begin
         flag_z_q <= (alu_y == '0);
         flag_c_q <= alu_cout;
      end
   end

   assign flag_z = flag_z_q;
   assign flag_c = flag_c_q;
`else
   logic cout_unused;
   assign cout_unused = alu_cout;
`endif

endmodule

// File: tb/tb_bus_cpu_core.sv
// Directed, table-driven bench for bus_cpu_core (DATA_W=8, NUM_REGS=4).
module tb_bus_cpu_core;

   localparam int unsigned DW = 8;

   localparam logic [2:0] MV = 3'd0, MVI = 3'd1, ADD = 3'd2, SUB = 3'd3,
                          AND = 3'd4, OR = 3'd5, XOR = 3'd6, ST = 3'd7;

   logic          clk = 1'b0;
   logic          clr_n = 1'b0;
   logic          w = 1'b0;
   logic [6:0]    func = '0;
   logic [DW-1:0] data_in = '0;
   logic [DW-1:0] data_out;
   logic          data_out_valid, busy, done;
`ifdef CPU_FLAGS_EN
   logic          flag_z, flag_c;
`endif

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   bus_cpu_core #(.DATA_W(DW), .NUM_REGS(4)) dut (
      .clk            (clk),
      .clr_n          (clr_n),
      .w              (w),
      .func           (func),
      .data_in        (data_in),
      .data_out       (data_out),
      .data_out_valid (data_out_valid),
      .busy           (busy),
      .done           (done)
`ifdef CPU_FLAGS_EN
      ,
      .flag_z         (flag_z),
      .flag_c         (flag_c)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  op;
      logic [1:0]  rx;
      logic [1:0]  ry;
      logic [7:0]  din;
      int unsigned lat;
      logic [7:0]  dout;
      logic        vld;
      logic        z;
      logic        c;
   } vec_t;

   vec_t vt [23];

   function automatic vec_t mk(input logic [2:0] op, input logic [1:0] rx, input logic [1:0] ry,
                               input logic [7:0] din, input int unsigned lat, input logic [7:0] dout,
                               input logic vld, input logic z, input logic c);
      vec_t v;
      v.op = op; v.rx = rx; v.ry = ry; v.din = din; v.lat = lat;
      v.dout = dout; v.vld = vld; v.z = z; v.c = c;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      clr_n = 1'b0;
      w     = 1'b0;
      @(negedge clk);
      @(negedge clk);
      clr_n = 1'b1;
   endtask

   // Issues one instruction, returns cycles from accept edge to the done cycle;
   // returns at the negedge following the done cycle.
   task automatic exec(input logic [2:0] op, input logic [1:0] rx, input logic [1:0] ry,
                       input logic [7:0] din, output int unsigned lat);
      @(negedge clk);
      func    = {op, rx, ry};
      data_in = din;
      w       = 1'b1;
      @(negedge clk);
      w = 1'b0;
      check("busy_in_T1", busy, 1);
      lat = 1;
      while (!done && lat < 8) begin
         @(negedge clk);
         lat++;
      end
      @(negedge clk);
   endtask

   task automatic st_check(input string name, input logic [1:0] r, input logic [7:0] exp);
      int unsigned lat;
      exec(ST, r, 2'd0, 8'h00, lat);
      check({name, "_lat"}, lat, 1);
      check({name, "_dout"}, data_out, exp);
      check({name, "_valid"}, data_out_valid, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      int unsigned lat;

      vt[0]  = mk(MVI, 2'd0, 2'd0, 8'h5A, 1, 8'h00, 1'b0, 1'b0, 1'b0);
      vt[1]  = mk(ST,  2'd0, 2'd0, 8'h00, 1, 8'h5A, 1'b1, 1'b0, 1'b0);
      vt[2]  = mk(MVI, 2'd0, 2'd0, 8'hF0, 1, 8'h5A, 1'b0, 1'b0, 1'b0);
      vt[3]  = mk(MVI, 2'd1, 2'd0, 8'h20, 1, 8'h5A, 1'b0, 1'b0, 1'b0);
      vt[4]  = mk(ADD, 2'd0, 2'd1, 8'h00, 3, 8'h5A, 1'b0, 1'b0, 1'b1);
      vt[5]  = mk(ST,  2'd0, 2'd0, 8'h00, 1, 8'h10, 1'b1, 1'b0, 1'b1);
      vt[6]  = mk(MVI, 2'd2, 2'd0, 8'h33, 1, 8'h10, 1'b0, 1'b0, 1'b1);
      vt[7]  = mk(SUB, 2'd2, 2'd2, 8'h00, 3, 8'h10, 1'b0, 1'b1, 1'b1);
      vt[8]  = mk(ST,  2'd2, 2'd0, 8'h00, 1, 8'h00, 1'b1, 1'b1, 1'b1);
      vt[9]  = mk(MVI, 2'd3, 2'd0, 8'hC3, 1, 8'h00, 1'b0, 1'b1, 1'b1);
      vt[10] = mk(ST,  2'd3, 2'd0, 8'h00, 1, 8'hC3, 1'b1, 1'b1, 1'b1);
      vt[11] = mk(MV,  2'd1, 2'd3, 8'h00, 1, 8'hC3, 1'b0, 1'b1, 1'b1);
      vt[12] = mk(XOR, 2'd1, 2'd0, 8'h00, 3, 8'hC3, 1'b0, 1'b0, 1'b0);
      vt[13] = mk(ST,  2'd1, 2'd0, 8'h00, 1, 8'hD3, 1'b1, 1'b0, 1'b0);
      vt[14] = mk(MVI, 2'd2, 2'd0, 8'h0F, 1, 8'hD3, 1'b0, 1'b0, 1'b0);
      vt[15] = mk(AND, 2'd1, 2'd2, 8'h00, 3, 8'hD3, 1'b0, 1'b0, 1'b0);
      vt[16] = mk(ST,  2'd1, 2'd0, 8'h00, 1, 8'h03, 1'b1, 1'b0, 1'b0);
      vt[17] = mk(OR,  2'd2, 2'd0, 8'h00, 3, 8'h03, 1'b0, 1'b0, 1'b0);
      vt[18] = mk(ST,  2'd2, 2'd0, 8'h00, 1, 8'h1F, 1'b1, 1'b0, 1'b0);
      vt[19] = mk(ADD, 2'd3, 2'd3, 8'h00, 3, 8'h1F, 1'b0, 1'b0, 1'b1);
      vt[20] = mk(ST,  2'd3, 2'd0, 8'h00, 1, 8'h86, 1'b1, 1'b0, 1'b1);
      vt[21] = mk(SUB, 2'd0, 2'd2, 8'h00, 3, 8'h86, 1'b0, 1'b0, 1'b0);
      vt[22] = mk(ST,  2'd0, 2'd0, 8'h00, 1, 8'hF1, 1'b1, 1'b0, 1'b0);

      do_reset();
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_dout", data_out, 8'h00);
      check("rst_valid", data_out_valid, 0);
`ifdef CPU_FLAGS_EN
      check("rst_flag_z", flag_z, 0);
      check("rst_flag_c", flag_c, 0);
`endif

      for (int i = 0; i < 23; i++) begin
         exec(vt[i].op, vt[i].rx, vt[i].ry, vt[i].din, lat);
         check($sformatf("v%0d_lat", i), lat, vt[i].lat);
         check($sformatf("v%0d_busy", i), busy, 0);
         check($sformatf("v%0d_dout", i), data_out, vt[i].dout);
         check($sformatf("v%0d_valid", i), data_out_valid, vt[i].vld);
`ifdef CPU_FLAGS_EN
         check($sformatf("v%0d_flag_z", i), flag_z, vt[i].z);
         check($sformatf("v%0d_flag_c", i), flag_c, vt[i].c);
`endif
         @(negedge clk);
         check($sformatf("v%0d_valid_off", i), data_out_valid, 0);
      end

      // w during T2 must not disturb the instruction in flight.
      exec(MVI, 2'd0, 2'd0, 8'hF0, lat);
      exec(MVI, 2'd1, 2'd0, 8'h20, lat);
      @(negedge clk);
      func = {ADD, 2'd0, 2'd1};
      w    = 1'b1;
      @(negedge clk);
      w = 1'b0;
      @(negedge clk);
      check("ign_T2_done", done, 0);
      func    = {XOR, 2'd3, 2'd3};
      data_in = 8'h77;
      w       = 1'b1;
      @(negedge clk);
      w = 1'b0;
      check("ign_T3_done", done, 1);
      @(negedge clk);
      check("ign_idle_busy", busy, 0);
      check("ign_no_done", done, 0);
      st_check("ign_r0", 2'd0, 8'h10);
      st_check("ign_r3", 2'd3, 8'h86);
`ifdef CPU_FLAGS_EN
      check("ign_flag_z", flag_z, 0);
      check("ign_flag_c", flag_c, 1);
`endif

      // Reset during T2 aborts the ADD and clears all state.
      @(negedge clk);
      func = {ADD, 2'd0, 2'd1};
      w    = 1'b1;
      @(negedge clk);
      w = 1'b0;
      @(negedge clk);
      clr_n = 1'b0;
      #1;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_dout", data_out, 8'h00);
      @(negedge clk);
      check("abort_done_hold", done, 0);
      clr_n = 1'b1;
      @(negedge clk);
      check("abort_post_busy", busy, 0);
      check("abort_post_done", done, 0);
`ifdef CPU_FLAGS_EN
      check("abort_flag_z", flag_z, 0);
      check("abort_flag_c", flag_c, 0);
`endif
      st_check("abort_r0", 2'd0, 8'h00);
      st_check("abort_r1", 2'd1, 8'h00);
      st_check("abort_r3", 2'd3, 8'h00);

      // w held high: MV accepted every second cycle.
      exec(MVI, 2'd0, 2'd0, 8'h5A, lat);
      @(negedge clk);
      func = {MV, 2'd1, 2'd0};
      w    = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         check($sformatf("b2b_done_%0d", i), done, (i % 2 == 1) ? 1 : 0);
         check($sformatf("b2b_busy_%0d", i), busy, (i % 2 == 1) ? 1 : 0);
      end
      w = 1'b0;
      @(negedge clk);
      check("b2b_stop", busy, 0);
      st_check("b2b_r1", 2'd1, 8'h5A);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/bus_cpu_core.md
Name: bus_cpu_core

Overview:
- Parametrised successor of the team's 4-register, 8-bit bus CPU. Single shared internal bus, N-entry register file, A/G accumulator pair and a multi-cycle control FSM.
- Widens the data path and register count and adds AND/OR/XOR and a store-to-port op. Adds a busy/done handshake and a registered output-valid strobe.
- Sits between the external instruction/data source and the output consumer, as a drop-in core for the lab processor top level.

Parameters:
- DATA_W, 8: data/bus/register width in bits, ≥4.
- NUM_REGS, 4: general registers; power of two, ≥2. REG_IDX_W = $clog2(NUM_REGS) is a derived localparam.

Ports:
- clk, input, 1: single clock, rising edge.
- clr_n, input, 1: asynchronous active-low reset.
- w, input, 1: start strobe; sampled only in IDLE.
- func, input, 3+2*REG_IDX_W: {op[2:0], rx, ry}, with rx as the destination.
- data_in, input, DATA_W: immediate operand for MVI.
- data_out, output, DATA_W: registered store port.
- data_out_valid, output, 1: one-cycle pulse after a ST.
- busy, output, 1: high when the FSM is not in IDLE.
- done, output, 1: high during the final cycle of an instruction.

Behaviour:
- Reset (async, clr_n=0):
  - state=IDLE; all registers, IR, A and G cleared to 0.
  - data_out=0, data_out_valid=0, done=0, busy=0.
  - Asserting reset mid-instruction aborts it with no register write; the FSM resumes in IDLE after release.
- Opcodes:
  - 000 MV: rx<-ry
  - 001 MVI: rx<-data_in
  - 010 ADD: rx<-rx+ry
  - 011 SUB: rx<-rx-ry
  - 100 AND
  - 101 OR
  - 110 XOR
  - 111 ST: data_out<-rx
- FSM states: IDLE, T1, T2, T3.
- IDLE:
  - If w=1 at a rising edge, IR<=func and next state is T1.
  - Otherwise stay in IDLE.
  - w is ignored in every other state; no queueing.
- T1:
  - MV drives ry onto the bus; MVI drives data_in; ST drives rx. Each completes here: done=1, the write or store happens at the closing edge, then the FSM returns to IDLE.
  - data_in must be stable during T1 for MVI.
  - ALU ops drive rx onto the bus and load A. Next state is T2.
- T2: drive ry onto the bus; G<=ALU(A, bus); next state is T3.
- T3: drive G onto the bus; rx<=bus; done=1; next state is IDLE.
- Latency from the accepting edge to the result written:
  - MV/MVI/ST: 1 cycle.
  - ALU ops: 3 cycles.
  - Next accept is possible at the edge after done.
- Bus drivers: exactly one driver per cycle, implemented as a one-hot mux (no tri-states). In IDLE the bus value is don't-care and nothing is written.
- Arithmetic is modulo 2^DATA_W: SUB is A + ~bus + 1, and the carry is discarded unless flags are enabled.
- rx==ry is legal: ADD r1,r1 doubles r1, and SUB r1,r1 gives 0.
- data_out holds its value until the next ST. data_out_valid=1 for the one cycle following the ST write edge, registered.
- done and busy are Moore outputs decoded from state and IR.op.

Optional Feature:
- CPU_FLAGS_EN defined:
  - Adds output ports flag_z (1 bit) and flag_c (1 bit), both reset to 0.
  - Both are updated only at the T2 edge of ALU ops.
  - flag_z = (ALU result == 0).
  - flag_c = carry-out for ADD and no-borrow for SUB (carry of A+~B+1); flag_c=0 for logic ops.
  - MV/MVI/ST leave the flags unchanged.
- CPU_FLAGS_EN undefined: ports absent, no flag logic, carry-out unused.

Decomposition:
- Package bus_cpu_pkg holds:
  - op_e enum (OP_MV..OP_ST, 3 bits)
  - state_e enum (S_IDLE, S_T1, S_T2, S_T3)
  - bus-source select encoding
- One sub-module: bus_cpu_alu, purely combinational, parametrised by DATA_W. Inputs are op, a and b; outputs are y and cout.
- The register file and FSM stay in bus_cpu_core.

Test Plan (DATA_W=8, NUM_REGS=4):
- Reset, then MVI r0 with data_in=8'h5A and w=1 for one cycle → done high in the next cycle (T1), r0=5A after that edge, busy back to 0.
- r0=8'hF0, r1=8'h20: ADD r0,r1 → done in the 3rd cycle after accept, r0=8'h10. With CPU_FLAGS_EN: flag_c=1, flag_z=0.
- r2=8'h33: SUB r2,r2 → r2=0. With CPU_FLAGS_EN: flag_z=1, flag_c=1.
- r3=8'hC3: ST r3 → data_out=C3 and data_out_valid high for exactly 1 cycle. A following MV r1,r3 leaves data_out=C3 with no valid pulse.
- ADD in progress: pulse w with a different func during T2 → ignored, IR unchanged. Assert clr_n=0 in T2 → all registers 0, state IDLE, no done pulse.
- Back-to-back: w held high continuously with MV r1,r0 → one accept every 2 cycles (IDLE, T1), done pulses at a 2-cycle period.
